// File: rtl/jk_bank_arbiter_if.sv
// Requester/bank bundle between the two requesters, the JK flip-flop bank and the arbiter.
// The master side owns the requests and the bank readback; the slave side is the arbiter.
interface jk_bank_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic             req1;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [WIDTH-1:0] mask0;
    logic [WIDTH-1:0] mask1;
    logic [3:0]       cnt0;
    logic [3:0]       cnt1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             err;

    modport master (
        output req0, req1, op0, op1, mask0, mask1, cnt0, cnt1, q,
        input  ack0, ack1, j, k, rdata, busy, err
    );

    modport slave (
        input  req0, req1, op0, op1, mask0, mask1, cnt0, cnt1, q,
        output ack0, ack1, j, k, rdata, busy, err
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that lets two requesters drive a JK flip-flop bank for cnt+1 clocks,
// then waits one settle cycle, captures the bank state and acknowledges the winner.
module jk_bank_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    jk_bank_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    // Returns {j, k} for a command; the bank sees this only while in APPLY.
    function automatic logic [2*WIDTH-1:0] drive_jk(input logic [1:0] op, input logic [WIDTH-1:0] mask);
        logic [2*WIDTH-1:0] jk;
        case (op)
            OP_HOLD: jk = {{WIDTH{1'b0}}, {WIDTH{1'b0}}};
            OP_RST:  jk = {{WIDTH{1'b0}}, mask};
            OP_SET:  jk = {mask, {WIDTH{1'b0}}};
            OP_TGL:  jk = {mask, mask};
            default: jk = {{WIDTH{1'b0}}, {WIDTH{1'b0}}};
        endcase
        return jk;
    endfunction

    state_t             state_q;
    logic               last_q;
    logic               gnt_q;
    logic [3:0]         cnt_q;
    logic [WIDTH-1:0]   j_q;
    logic [WIDTH-1:0]   k_q;
    logic [WIDTH-1:0]   rdata_q;
    logic               ack0_q;
    logic               ack1_q;
    logic               err_q;
    logic               busy_q;

    logic               pick_s;
    logic [1:0]         op_s;
    logic [WIDTH-1:0]   mask_s;
    logic [3:0]         cnt_s;
    logic [2*WIDTH-1:0] jk_d;

    // Winner selection: contention goes to whoever was not granted last.
    always_comb begin
        pick_s = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick_s = ~last_q;
        end else if (bus.req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        op_s   = pick_s ? bus.op1   : bus.op0;
        mask_s = pick_s ? bus.mask1 : bus.mask0;
        cnt_s  = pick_s ? bus.cnt1  : bus.cnt0;
        jk_d   = drive_jk(op_s, mask_s);
    end

    // Control FSM; every output is a register so reset clears the bank drive immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            cnt_q   <= 4'd0;
            j_q     <= {WIDTH{1'b0}};
            k_q     <= {WIDTH{1'b0}};
            rdata_q <= {WIDTH{1'b0}};
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt_q  <= pick_s;
                        last_q <= pick_s;
                        cnt_q  <= cnt_s;
                        busy_q <= 1'b1;
                        if (mask_s == {WIDTH{1'b0}}) begin
                            // Nothing to drive: acknowledge at once and flag the empty mask.
                            state_q <= DONE;
                            ack0_q  <= ~pick_s;
                            ack1_q  <= pick_s;
                            err_q   <= 1'b1;
                            rdata_q <= bus.q;
                        end else begin
                            state_q <= APPLY;
                            j_q     <= jk_d[2*WIDTH-1:WIDTH];
                            k_q     <= jk_d[WIDTH-1:0];
                        end
                    end
                end
                APPLY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= SETTLE;
                        j_q     <= {WIDTH{1'b0}};
                        k_q     <= {WIDTH{1'b0}};
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SETTLE: begin
                    state_q <= DONE;
                    rdata_q <= bus.q;
                    ack0_q  <= ~gnt_q;
                    ack1_q  <= gnt_q;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    j_q     <= {WIDTH{1'b0}};
                    k_q     <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.j     = j_q;
    assign bus.k     = k_q;
    assign bus.rdata = rdata_q;
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: number of JK flip-flops in the controlled bank.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1  request from requester 0 / 1; held high until that requester's ack.
REQ-005 op0 / op1  input  2  command: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-006 mask0 / mask1  input  WIDTH  flip-flops affected by the command.
REQ-007 cnt0 / cnt1  input  4  extra apply cycles; apply length = cnt+1 clocks.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 j  output  WIDTH  J drive to the bank, registered.
REQ-010 k  output  WIDTH  K drive to the bank, registered.
REQ-011 q  input  WIDTH  bank state readback.
REQ-012 rdata  output  WIDTH  bank state captured at completion; valid while ackN=1.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 err  output  1  one-cycle pulse, coincident with ack, when the granted mask is all zero.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, SETTLE and DONE.
REQ-016 op, mask and cnt SHALL be sampled only on the IDLE->APPLY edge; later changes SHALL be ignored.
REQ-017 Arbitration SHALL be round-robin: on simultaneous req0 and req1 in IDLE, the requester not granted last SHALL win.
REQ-018 A single pending request SHALL be granted regardless of the round-robin pointer.
REQ-019 The pointer SHALL update only on a grant.
REQ-020 IDLE -> APPLY SHALL occur on the clock after any req is seen high in IDLE (cycle t).
REQ-021 APPLY SHALL last exactly cnt+1 cycles (t+1 .. t+1+cnt).
REQ-022 In APPLY, drive SHALL be: hold j=0,k=0; reset j=0,k=mask; set j=mask,k=0; toggle j=mask,k=mask.
REQ-023 Outside APPLY, j and k SHALL be all-zero.
REQ-024 SETTLE SHALL last one cycle (t+2+cnt), with j=k=0; rdata SHALL capture q at the end of SETTLE.
REQ-025 DONE SHALL last one cycle (t+3+cnt), with ack of the granted requester =1; then the FSM SHALL return to IDLE.
REQ-026 Total latency from req seen at cycle t to ack SHALL be cnt+3 cycles.
REQ-027 The requester SHALL drop req in the cycle after ack; req still high in IDLE SHALL be treated as a new request.
REQ-028 A granted mask of all zeros SHALL skip APPLY and SETTLE: IDLE -> DONE with ack=1, err=1, rdata=q.
REQ-029 ack0 and ack1 SHALL never be high simultaneously; err SHALL be 0 except as defined in REQ-014 and REQ-028.
REQ-030 cnt=15 SHALL yield 16 apply cycles, with no wrap to 0.

Reset
REQ-031 While rst_n=0: FSM=IDLE; j=0, k=0, ack0=0, ack1=0, err=0, busy=0, rdata=0.
REQ-032 While rst_n=0, the round-robin pointer SHALL favour requester 0 on the first contention.
REQ-033 Reset asserted mid-operation SHALL immediately zero j and k.
REQ-034 An operation interrupted by reset SHALL be abandoned without ack; the requester reissues.

Verification
REQ-035 Bench SHALL drive q from a behavioural JK bank clocked by clk: q <= (j & ~q) | (~k & q).
REQ-036 Set: from q=0000, req0 op=10 mask=1010 cnt=0 -> j=1010 for 1 cycle; ack0 at t+3; rdata=1010.
REQ-037 Toggle: from q=0000, req1 op=11 mask=0011 cnt=2 -> 3 toggles; ack1 at t+5; rdata=0011.
REQ-038 Contention after reset: req0 and req1 both high -> req0 served first, then req1; next contention -> req0 again.
REQ-039 Zero mask: req0 op=01 mask=0000 -> no j/k activity; ack0=1 and err=1 at t+1.
REQ-040 Reset mid-APPLY: rst_n low during cnt=5 toggle -> j=k=0 at once, no ack; after release, a reissued request completes normally.
